// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 control FSM sequencing a shared-ALU datapath; halts on illegal opcode or dmem timeout.
// Optional performance counters (cycle_cnt, instr_cnt) are enabled by defining MULTICYCLE_PERF_EN.
module multicycle_ctrl #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] Op,
  input  logic        Zero,
  input  logic        dmem_ready,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        IRWrite,
  output logic        Reg2Loc,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [1:0]  ALUOp,
  output logic        halted,
  output logic [1:0]  err_code,
  output logic [3:0]  state_o
`ifdef MULTICYCLE_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_ADDR   = 4'd2,
    S_MEM_RD = 4'd3,
    S_WB_LD  = 4'd4,
    S_MEM_WR = 4'd5,
    S_EXEC_R = 4'd6,
    S_WB_R   = 4'd7,
    S_BRANCH = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
  localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
  localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
  localparam logic [10:0] OP_SUB  = 11'b110_0101_1000;
  localparam logic [10:0] OP_AND  = 11'b100_0101_0000;
  localparam logic [10:0] OP_ORR  = 11'b101_0101_0000;

  // MAX_WAIT=0 disables the timeout; keep a 1-bit counter so widths stay legal.
  localparam int          CW         = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam bit          TIMEOUT_EN = (MAX_WAIT > 0);
  localparam logic [CW-1:0] WAIT_LIM = CW'(MAX_WAIT);
  localparam logic [CW-1:0] WAIT_SAT = '1;

  state_t        state_q, state_d;
  logic [10:0]   op_q, op_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [1:0]    err_q, err_d;

  logic is_mem, is_rtype, is_cbz, op_is_stur, at_limit;

  assign is_mem     = (Op == OP_LDUR) || (Op == OP_STUR);
  assign is_rtype   = (Op == OP_ADD) || (Op == OP_SUB) || (Op == OP_AND) || (Op == OP_ORR);
  assign is_cbz     = (Op[10:3] == 8'b1011_0100);
  assign op_is_stur = (op_q == OP_STUR);
  assign at_limit   = TIMEOUT_EN && (wait_q == WAIT_LIM);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    wait_d   = wait_q;
    err_d    = err_q;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    IRWrite  = 1'b0;
    Reg2Loc  = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    ALUOp    = 2'b00;
    halted   = 1'b0;
    err_code = err_q;
    state_o  = state_q;

    case (state_q)
      S_FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        op_d = Op;
        if (is_mem)        state_d = S_ADDR;
        else if (is_rtype) state_d = S_EXEC_R;
        else if (is_cbz)   state_d = S_BRANCH;
        else begin
          state_d = S_HALT;
          err_d   = 2'b01;
        end
      end
      S_ADDR: begin
        ALUSrc  = 1'b1;
        Reg2Loc = op_is_stur;
        wait_d  = '0;
        state_d = op_is_stur ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD, S_MEM_WR: begin
        MemRead  = (state_q == S_MEM_RD);
        MemWrite = (state_q == S_MEM_WR);
        Reg2Loc  = (state_q == S_MEM_WR);
        // Ready on the limit cycle still completes the access.
        if (dmem_ready) begin
          state_d = (state_q == S_MEM_RD) ? S_WB_LD : S_FETCH;
        end else if (at_limit) begin
          state_d = S_HALT;
          err_d   = 2'b10;
        end else if (wait_q != WAIT_SAT) begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB_LD: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXEC_R: begin
        ALUOp   = 2'b10;
        state_d = S_WB_R;
      end
      S_WB_R: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        Reg2Loc = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 1'b1;
        PCWrite = Zero;
        state_d = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    if (reset) begin
      PCWrite  = 1'b0;
      PCSrc    = 1'b0;
      IRWrite  = 1'b0;
      Reg2Loc  = 1'b0;
      ALUSrc   = 1'b0;
      MemtoReg = 1'b0;
      RegWrite = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      ALUOp    = 2'b00;
      halted   = 1'b0;
      err_code = 2'b00;
      state_o  = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      wait_q  <= '0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

`ifdef MULTICYCLE_PERF_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic        instr_done;

  assign instr_done = (state_d == S_FETCH) &&
                      ((state_q == S_WB_LD) || (state_q == S_MEM_WR) ||
                       (state_q == S_WB_R)  || (state_q == S_BRANCH));

  always_comb begin
    cycle_cnt_d = (state_q != S_HALT) ? cycle_cnt_q + 32'd1 : cycle_cnt_q;
    instr_cnt_d = instr_done ? instr_cnt_q + 32'd1 : instr_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_cnt = reset ? 32'd0 : cycle_cnt_q;
  assign instr_cnt = reset ? 32'd0 : instr_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected control vectors are queued by each
// scenario task and compared by a negedge monitor; a MAX_WAIT=4 instance covers the timeout path.
module tb_multicycle_ctrl;

  localparam logic [3:0] F = 4'd0, D = 4'd1, AD = 4'd2, MR = 4'd3, WL = 4'd4;
  localparam logic [3:0] MW = 4'd5, EX = 4'd6, WR = 4'd7, BR = 4'd8, HT = 4'd9;

  localparam logic [10:0] LDUR = 11'b111_1100_0010;
  localparam logic [10:0] STUR = 11'b111_1100_0000;
  localparam logic [10:0] ADD  = 11'b100_0101_1000;
  localparam logic [10:0] SUB  = 11'b110_0101_1000;
  localparam logic [10:0] ANDI = 11'b100_0101_0000;
  localparam logic [10:0] ORR  = 11'b101_0101_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] Op = '0;
  logic        Zero = 1'b0;
  logic        dmem_ready = 1'b0;

  logic pcw_0, pcs_0, irw_0, r2l_0, alus_0, m2r_0, rw_0, mr_0, mw_0, h_0;
  logic [1:0] aop_0, err_0;
  logic [3:0] st_0;
  logic pcw_4, pcs_4, irw_4, r2l_4, alus_4, m2r_4, rw_4, mr_4, mw_4, h_4;
  logic [1:0] aop_4, err_4;
  logic [3:0] st_4;
`ifdef MULTICYCLE_PERF_EN
  logic [31:0] cyc_0, ins_0, cyc_4, ins_4;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .dmem_ready(dmem_ready),
    .PCWrite(pcw_0), .PCSrc(pcs_0), .IRWrite(irw_0), .Reg2Loc(r2l_0), .ALUSrc(alus_0),
    .MemtoReg(m2r_0), .RegWrite(rw_0), .MemRead(mr_0), .MemWrite(mw_0), .ALUOp(aop_0),
    .halted(h_0), .err_code(err_0), .state_o(st_0)
`ifdef MULTICYCLE_PERF_EN
    , .cycle_cnt(cyc_0), .instr_cnt(ins_0)
`endif
  );

  multicycle_ctrl #(.MAX_WAIT(4)) dut4 (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .dmem_ready(dmem_ready),
    .PCWrite(pcw_4), .PCSrc(pcs_4), .IRWrite(irw_4), .Reg2Loc(r2l_4), .ALUSrc(alus_4),
    .MemtoReg(m2r_4), .RegWrite(rw_4), .MemRead(mr_4), .MemWrite(mw_4), .ALUOp(aop_4),
    .halted(h_4), .err_code(err_4), .state_o(st_4)
`ifdef MULTICYCLE_PERF_EN
    , .cycle_cnt(cyc_4), .instr_cnt(ins_4)
`endif
  );

  // Observation vector: {state, PCWrite, PCSrc, IRWrite, Reg2Loc, ALUSrc, MemtoReg, RegWrite,
  // MemRead, MemWrite, ALUOp, halted, err_code}
  logic [17:0] obs0, obs4;
  assign obs0 = {st_0, pcw_0, pcs_0, irw_0, r2l_0, alus_0, m2r_0, rw_0, mr_0, mw_0, aop_0, h_0, err_0};
  assign obs4 = {st_4, pcw_4, pcs_4, irw_4, r2l_4, alus_4, m2r_4, rw_4, mr_4, mw_4, aop_4, h_4, err_4};

  logic [17:0] exp_q[$];
  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic        sel4 = 1'b0;
  logic        mon_en = 1'b1;
  string       tag = "reset";

  function automatic logic [17:0] ev(input logic [3:0] st, input logic stur, input logic z,
                                     input logic [1:0] err);
    logic pcw, pcs, irw, r2l, alus, m2r, rw, mr, mw, h;
    logic [1:0] aop, e;
    {pcw, pcs, irw, r2l, alus, m2r, rw, mr, mw, h} = '0;
    aop = 2'b00;
    e   = 2'b00;
    case (st)
      F:  begin pcw = 1'b1; irw = 1'b1; end
      AD: begin alus = 1'b1; r2l = stur; end
      MR: mr = 1'b1;
      WL: begin rw = 1'b1; m2r = 1'b1; end
      MW: begin mw = 1'b1; r2l = 1'b1; end
      EX: aop = 2'b10;
      WR: rw = 1'b1;
      BR: begin r2l = 1'b1; aop = 2'b01; pcs = 1'b1; pcw = z; end
      HT: begin h = 1'b1; e = err; end
      default: ;
    endcase
    return {st, pcw, pcs, irw, r2l, alus, m2r, rw, mr, mw, aop, h, e};
  endfunction

  // Scoreboard: one expected vector is consumed per driven cycle.
  always begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      logic [17:0] o, e;
      o = sel4 ? obs4 : obs0;
      vec_cnt++;
      if (exp_q.size() == 0) begin
        err_cnt++;
        $display("FAIL %s: scoreboard empty, got %h", tag, o);
      end else begin
        e = exp_q.pop_front();
        if (o !== e) begin
          err_cnt++;
          $display("FAIL %s: got %h required %h (t=%0t)", tag, o, e, $time);
        end
      end
    end
  end

  task automatic drv(input logic r, input logic [10:0] op, input logic z, input logic rdy);
    @(negedge clk);
    reset      = r;
    Op         = op;
    Zero       = z;
    dmem_ready = rdy;
  endtask

  task automatic test_reset();
    tag = "reset";
    repeat (2) begin
      exp_q.push_back(18'd0);
      drv(1'b1, ADD, 1'b1, 1'b1);
    end
  endtask

  task automatic test_rtype();
    logic [10:0] ops [6];
    ops = '{ADD, SUB, ANDI, ORR, ADD, ORR};
    ops[4] = ($urandom_range(0, 1) == 0) ? SUB : ANDI;
    for (int i = 0; i < 6; i++) begin
      tag = $sformatf("rtype%0d", i);
      exp_q.push_back(ev(F, 0, 0, 0));
      exp_q.push_back(ev(D, 0, 0, 0));
      exp_q.push_back(ev(EX, 0, 0, 0));
      exp_q.push_back(ev(WR, 0, 0, 0));
      repeat (4) drv(1'b0, ops[i], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_mem();
    logic rdy [8];
    tag = "ldur_wait";
    rdy = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_q.push_back(ev(F, 0, 0, 0));
    exp_q.push_back(ev(D, 0, 0, 0));
    exp_q.push_back(ev(AD, 0, 0, 0));
    repeat (4) exp_q.push_back(ev(MR, 0, 0, 0));
    exp_q.push_back(ev(WL, 0, 0, 0));
    for (int i = 0; i < 8; i++) drv(1'b0, LDUR, 1'b0, rdy[i]);
    tag = "stur_nowait";
    exp_q.push_back(ev(F, 0, 0, 0));
    exp_q.push_back(ev(D, 0, 0, 0));
    exp_q.push_back(ev(AD, 1, 0, 0));
    exp_q.push_back(ev(MW, 0, 0, 0));
    repeat (4) drv(1'b0, STUR, 1'b0, 1'b1);
  endtask

  task automatic test_cbz();
    logic [10:0] op;
    for (int z = 0; z < 2; z++) begin
      tag = $sformatf("cbz_z%0d", z);
      op = {8'b1011_0100, 3'($urandom_range(0, 7))};
      exp_q.push_back(ev(F, 0, 0, 0));
      exp_q.push_back(ev(D, 0, 0, 0));
      exp_q.push_back(ev(BR, 0, 1'(z), 0));
      drv(1'b0, op, 1'(1 - z), 1'b1);
      drv(1'b0, op, 1'(1 - z), 1'b0);
      drv(1'b0, op, 1'(z), 1'b1);
    end
  endtask

  task automatic test_illegal();
    tag = "illegal_zero";
    exp_q.push_back(ev(F, 0, 0, 0));
    exp_q.push_back(ev(D, 0, 0, 0));
    repeat (20) exp_q.push_back(ev(HT, 0, 0, 2'b01));
    repeat (22) drv(1'b0, 11'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    #3;
    vec_cnt++;
    if (h_0 !== 1'b1 || err_0 !== 2'b01) begin
      err_cnt++;
      $display("FAIL illegal_hold: halted=%b err=%b required 1/01", h_0, err_0);
    end
    tag = "illegal_reset";
    exp_q.push_back(18'd0);
    drv(1'b1, 11'd0, 1'b0, 1'b0);
    // CBNZ encoding sits next to CBZ but is not decoded
    tag = "illegal_cbnz";
    exp_q.push_back(ev(F, 0, 0, 0));
    exp_q.push_back(ev(D, 0, 0, 0));
    exp_q.push_back(ev(HT, 0, 0, 2'b01));
    repeat (3) drv(1'b0, 11'b101_1010_1000, 1'b1, 1'b1);
    exp_q.push_back(18'd0);
    drv(1'b1, 11'd0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    @(posedge clk);
    sel4 = 1'b1;
    tag = "timeout_stuck";
    exp_q.push_back(ev(F, 0, 0, 0));
    exp_q.push_back(ev(D, 0, 0, 0));
    exp_q.push_back(ev(AD, 1, 0, 0));
    repeat (5) exp_q.push_back(ev(MW, 0, 0, 0));
    repeat (3) exp_q.push_back(ev(HT, 0, 0, 2'b10));
    repeat (11) drv(1'b0, STUR, 1'b0, 1'b0);
    #3;
    vec_cnt++;
    if (mw_4 !== 1'b0 || err_4 !== 2'b10) begin
      err_cnt++;
      $display("FAIL timeout_halt: MemWrite=%b err=%b required 0/10", mw_4, err_4);
    end
    exp_q.push_back(18'd0);
    drv(1'b1, STUR, 1'b0, 1'b0);
    // ready arrives on the cycle the counter sits at the limit
    tag = "timeout_edge";
    exp_q.push_back(ev(F, 0, 0, 0));
    exp_q.push_back(ev(D, 0, 0, 0));
    exp_q.push_back(ev(AD, 1, 0, 0));
    repeat (5) exp_q.push_back(ev(MW, 0, 0, 0));
    exp_q.push_back(ev(F, 0, 0, 0));
    repeat (7) drv(1'b0, STUR, 1'b0, 1'b0);
    drv(1'b0, STUR, 1'b0, 1'b1);
    drv(1'b0, STUR, 1'b0, 1'b0);
    exp_q.push_back(18'd0);
    drv(1'b1, STUR, 1'b0, 1'b0);
    @(posedge clk);
    sel4 = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    tag = "reset_mid_wait";
    exp_q.push_back(ev(F, 0, 0, 0));
    exp_q.push_back(ev(D, 0, 0, 0));
    exp_q.push_back(ev(AD, 0, 0, 0));
    repeat (2) exp_q.push_back(ev(MR, 0, 0, 0));
    exp_q.push_back(18'd0);
    exp_q.push_back(ev(F, 0, 0, 0));
    repeat (5) drv(1'b0, LDUR, 1'b0, 1'b0);
    drv(1'b1, LDUR, 1'b0, 1'b0);
    #3;
    vec_cnt++;
    if (mr_0 !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_memread: MemRead=%b required 0", mr_0);
    end
    drv(1'b0, LDUR, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [10:0] cbz;
    cbz = {8'b1011_0100, 3'($urandom_range(0, 7))};
    tag = "b2b";
    exp_q.push_back(18'd0);
    drv(1'b1, ADD, 1'b0, 1'b1);
    exp_q.push_back(ev(F, 0, 0, 0));
    exp_q.push_back(ev(D, 0, 0, 0));
    exp_q.push_back(ev(EX, 0, 0, 0));
    exp_q.push_back(ev(WR, 0, 0, 0));
    repeat (4) drv(1'b0, ADD, 1'b0, 1'b1);
    exp_q.push_back(ev(F, 0, 0, 0));
    exp_q.push_back(ev(D, 0, 0, 0));
    exp_q.push_back(ev(AD, 1, 0, 0));
    exp_q.push_back(ev(MW, 0, 0, 0));
    repeat (4) drv(1'b0, STUR, 1'b0, 1'b1);
    exp_q.push_back(ev(F, 0, 0, 0));
    exp_q.push_back(ev(D, 0, 0, 0));
    exp_q.push_back(ev(BR, 0, 1, 0));
    exp_q.push_back(ev(F, 0, 0, 0));
    repeat (4) drv(1'b0, cbz, 1'b1, 1'b1);
`ifdef MULTICYCLE_PERF_EN
    #3;
    vec_cnt++;
    if (ins_0 !== 32'd3) begin
      err_cnt++;
      $display("FAIL instr_cnt: got %0d required 3", ins_0);
    end
    vec_cnt++;
    if (cyc_0 !== 32'd11) begin
      err_cnt++;
      $display("FAIL cycle_cnt: got %0d required 11", cyc_0);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_mem();
    test_cbz();
    test_illegal();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    @(posedge clk);
    mon_en = 1'b0;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL scoreboard_drain: %0d expectations left", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
